ghost_direction_engine: RTL

Parametrised, time-multiplexed direction engine that replaces the per-colour ghost direction modules. On each game tick it snapshots Pacman and all ghost coordinates, then computes one ghost per cycle through a 2-stage pipeline. Each ghost has its own strategy: chase, flank, evade or patrol. A scatter/chase/frightened mode timer sits on top of the strategies. It sits between the position registers and the ghost movement logic and publishes all dx/dy pairs at once with a one-cycle valid strobe.

---
 rtl/ghost_direction_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ghost_direction_engine.sv
// Time-multiplexed ghost direction engine: one ghost per cycle through a
// 2-stage pipeline, with a scatter/chase/frightened mode timer on top.
module ghost_direction_engine #(
   parameter int                  W             = 9,
   parameter int                  NGHOST        = 4,
   parameter logic [2*NGHOST-1:0] STRAT         = {2'd3, 2'd2, 2'd1, 2'd0},
   parameter int                  SCATTER_TICKS = 7,
   parameter int                  CHASE_TICKS   = 20,
   parameter int                  FRIGHT_TICKS  = 6,
   parameter logic [15:0]         LFSR_SEED     = 16'hACE1
) (
   input  logic                  clock_in,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  power_pellet,
   input  logic [W-1:0]          pacmanx,
   input  logic [W-1:0]          pacmany,
   input  logic [NGHOST*W-1:0]   ghostx,
   input  logic [NGHOST*W-1:0]   ghosty,
   output logic [2*NGHOST-1:0]   dx,
   output logic [2*NGHOST-1:0]   dy,
   output logic                  valid,
   output logic                  busy,
   output logic [1:0]            mode
);

   localparam int VW = W + 2;
   localparam int CW = 16;
   localparam int PW = $clog2(NGHOST + 2);

   typedef enum logic [1:0] {
      M_SCATTER = 2'b00,
      M_CHASE   = 2'b01,
      M_FRIGHT  = 2'b10
   } mode_e;

   mode_e                     mode_d, mode_q, smode_d, smode_q;
   logic [CW-1:0]             cnt_d, cnt_q;
   logic [15:0]               lfsr_d, lfsr_q;
   logic                      busy_d, busy_q;
   logic [PW-1:0]             ph_d, ph_q;
   logic [W-1:0]              px_d, px_q, py_d, py_q;
   logic [NGHOST*W-1:0]       gx_d, gx_q, gy_d, gy_q;
   logic                      s1_vld_d, s1_vld_q;
   logic [PW-1:0]             s1_idx_d, s1_idx_q;
   logic signed [VW-1:0]      vx_d, vx_q, vy_d, vy_q;
   logic                      s1_inv_d, s1_inv_q, s1_fr_d, s1_fr_q;
   logic [2*NGHOST-1:0]       sh_dx_d, sh_dx_q, sh_dy_d, sh_dy_q;
   logic [2*NGHOST-1:0]       dx_d, dx_q, dy_d, dy_q;
   logic                      valid_d, valid_q;
   logic                      publish_s, start_s;
   logic [PW-1:0]             gsel_s;
   logic [1:0]                strat_s;
   logic [W-1:0]              cx_s, cy_s;

   // Signed target-minus-ghost on one axis; W+2 bits hold the flank sum without wrap.
   function automatic logic signed [VW-1:0] axis_vec(input logic [W-1:0] p, input logic [W-1:0] g,
                                                     input logic [W-1:0] g0, input logic [W-1:0] c,
                                                     input logic use_c, input logic flank);
      logic signed [VW-1:0] ps, gs, g0s, cs, sum;
      ps  = $signed({2'b00, p});
      gs  = $signed({2'b00, g});
      g0s = $signed({2'b00, g0});
      cs  = $signed({2'b00, c});
      sum = (ps - gs) + (g0s - gs);
      if (use_c) begin
         axis_vec = cs - gs;
      end else if (flank) begin
         axis_vec = sum >>> 1;
      end else begin
         axis_vec = ps - gs;
      end
   endfunction

   function automatic logic [1:0] map_dir(input logic signed [VW-1:0] v, input logic inv);
      if (v == {VW{1'b0}}) begin
         map_dir = 2'b00;
      end else if (v[VW-1] == 1'b0) begin
         map_dir = inv ? 2'b10 : 2'b01;
      end else begin
         map_dir = inv ? 2'b01 : 2'b10;
      end
   endfunction

   function automatic logic [1:0] rnd_dir(input logic [1:0] r);
      rnd_dir = (r == 2'b11) ? 2'b00 : r;
   endfunction

   // Mode timer and LFSR; a pellet beats any simultaneous tick or expiry.
   always_comb begin
      mode_d = mode_q;
      cnt_d  = cnt_q;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (power_pellet) begin
         mode_d = M_FRIGHT;
         cnt_d  = CW'(FRIGHT_TICKS);
      end else if (tick) begin
         if (cnt_q == CW'(1)) begin
            case (mode_q)
               M_SCATTER: begin mode_d = M_CHASE;   cnt_d = CW'(CHASE_TICKS);   end
               M_CHASE:   begin mode_d = M_SCATTER; cnt_d = CW'(SCATTER_TICKS); end
               M_FRIGHT:  begin mode_d = M_CHASE;   cnt_d = CW'(CHASE_TICKS);   end
               default:   begin mode_d = M_SCATTER; cnt_d = CW'(SCATTER_TICKS); end
            endcase
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Frame sequencing: a tick landing on the publish edge chains straight into a new frame.
   always_comb begin
      publish_s = busy_q && (ph_q == PW'(NGHOST + 1));
      start_s   = tick && (!busy_q || publish_s);
      busy_d    = busy_q;
      ph_d      = ph_q;
      px_d      = px_q;
      py_d      = py_q;
      gx_d      = gx_q;
      gy_d      = gy_q;
      smode_d   = smode_q;
      if (start_s) begin
         busy_d  = 1'b1;
         ph_d    = {PW{1'b0}};
         px_d    = pacmanx;
         py_d    = pacmany;
         gx_d    = ghostx;
         gy_d    = ghosty;
         smode_d = mode_q;
      end else if (publish_s) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         ph_d = ph_q + PW'(1);
      end else begin
         ph_d = ph_q;
      end
   end

   // Stage 1: vector to target for the ghost selected by the phase counter.
   always_comb begin
      gsel_s   = (ph_q < PW'(NGHOST)) ? ph_q : {PW{1'b0}};
      strat_s  = STRAT[2*gsel_s +: 2];
      cx_s     = gsel_s[0] ? {W{1'b0}} : {W{1'b1}};
      cy_s     = gsel_s[1] ? {W{1'b1}} : {W{1'b0}};
      s1_vld_d = busy_q && (ph_q < PW'(NGHOST));
      s1_idx_d = gsel_s;
      vx_d     = axis_vec(px_q, gx_q[W*gsel_s +: W], gx_q[W-1:0], cx_s,
                          (smode_q == M_SCATTER) || (strat_s == 2'd3), strat_s == 2'd1);
      vy_d     = axis_vec(py_q, gy_q[W*gsel_s +: W], gy_q[W-1:0], cy_s,
                          (smode_q == M_SCATTER) || (strat_s == 2'd3), strat_s == 2'd1);
      s1_inv_d = (smode_q == M_CHASE) && (strat_s == 2'd2);
      s1_fr_d  = (smode_q == M_FRIGHT);
   end

   // Stage 2 fills the shadow set; outputs only change on the publish edge.
   always_comb begin
      sh_dx_d = sh_dx_q;
      sh_dy_d = sh_dy_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      valid_d = 1'b0;
      if (s1_vld_q) begin
         sh_dx_d[2*s1_idx_q +: 2] = s1_fr_q ? rnd_dir(lfsr_q[1:0]) : map_dir(vx_q, s1_inv_q);
         sh_dy_d[2*s1_idx_q +: 2] = s1_fr_q ? rnd_dir(lfsr_q[3:2]) : map_dir(vy_q, s1_inv_q);
      end else begin
         sh_dx_d = sh_dx_q;
      end
      if (publish_s) begin
         dx_d    = sh_dx_q;
         dy_d    = sh_dy_q;
         valid_d = 1'b1;
      end else begin
         valid_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         mode_q   <= M_SCATTER;
         cnt_q    <= CW'(SCATTER_TICKS);
         lfsr_q   <= LFSR_SEED;
         busy_q   <= 1'b0;
         ph_q     <= {PW{1'b0}};
         px_q     <= {W{1'b0}};
         py_q     <= {W{1'b0}};
         gx_q     <= {(NGHOST*W){1'b0}};
         gy_q     <= {(NGHOST*W){1'b0}};
         smode_q  <= M_SCATTER;
         s1_vld_q <= 1'b0;
         s1_idx_q <= {PW{1'b0}};
         vx_q     <= {VW{1'b0}};
         vy_q     <= {VW{1'b0}};
         s1_inv_q <= 1'b0;
         s1_fr_q  <= 1'b0;
         sh_dx_q  <= {(2*NGHOST){1'b0}};
         sh_dy_q  <= {(2*NGHOST){1'b0}};
         dx_q     <= {(2*NGHOST){1'b0}};
         dy_q     <= {(2*NGHOST){1'b0}};
         valid_q  <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         lfsr_q   <= lfsr_d;
         busy_q   <= busy_d;
         ph_q     <= ph_d;
         px_q     <= px_d;
         py_q     <= py_d;
         gx_q     <= gx_d;
         gy_q     <= gy_d;
         smode_q  <= smode_d;
         s1_vld_q <= s1_vld_d;
         s1_idx_q <= s1_idx_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         s1_inv_q <= s1_inv_d;
         s1_fr_q  <= s1_fr_d;
         sh_dx_q  <= sh_dx_d;
         sh_dy_q  <= sh_dy_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         valid_q  <= valid_d;
      end
   end

   assign dx    = dx_q;
   assign dy    = dy_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign mode  = mode_q;

endmodule
